qq_op_sched: RTL and testbench
==============================

Name: qq_op_sched

Overview:
- Operation scheduler for the Quick Priority Queue register array.
- Accepts enqueue and dequeue requests over valid/ready handshakes and merges a simultaneous pair into one REPLACE operation.
- Issues one operation at a time to the array as a one-cycle enable strobe with an opcode and key, then waits a fixed settle time.
- Tracks occupancy and returns the dequeued (head) key to the requester.

Parameters:
- DEPTH, 16, number of array entries; must be ≥ 2.
- KW, 8, key width in bits.
- SETTLE, 2, cycles the array needs after an enable strobe before its head is valid; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enq_valid  in  1  enqueue request.
- enq_key  in  KW  key to insert.
- enq_ready  out  1  enqueue accepted this cycle when high together with enq_valid.
- deq_valid  in  1  dequeue request.
- deq_ready  out  1  dequeue accepted this cycle when high together with deq_valid.
- deq_key  out  KW  removed head key, registered.
- deq_key_valid  out  1  one-cycle pulse qualifying deq_key.
- arr_head_key  in  KW  current head (highest-priority) key from the array.
- arr_enb  out  1  array enable strobe.
- arr_op  out  2  opcode: 00 NOP, 01 ENQ, 10 DEQ, 11 REPLACE.
- arr_key  out  KW  key driven to the array with ENQ/REPLACE.
- count  out  $clog2(DEPTH+1)  occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - count=0, deq_key=0, deq_key_valid=0, arr_enb=0, arr_op=00, arr_key=0, settle counter=0.
  - The array must be reset by the same rst; reset mid-operation abandons the operation with no completion pulse.
- States:
  - IDLE: handshakes are open.
  - ISSUE: exactly one cycle.
  - WAIT: SETTLE cycles.
  - WAIT returns to IDLE.
- Ready rules (combinational, asserted only in IDLE):
  - deq_ready = !empty.
  - enq_ready = !full | (deq_valid & !empty).
  - Ready is low in ISSUE and WAIT.
- Accept rules (IDLE, on the clock edge):
  - deq_fire = deq_valid & deq_ready.
  - enq_fire = enq_valid & enq_ready.
  - Both fire: register REPLACE. count is unchanged, and this is legal even when full.
  - Only enq_fire: register ENQ.
  - Only deq_fire: register DEQ.
  - Empty with both valid: only the ENQ is accepted; the DEQ stays pending and is retried after the operation completes.
  - Any fire moves the FSM to ISSUE. With no fire, the FSM stays in IDLE.
- Dequeue data capture:
  - On a deq_fire edge, deq_key <= arr_head_key.
  - deq_key_valid is high for exactly the following cycle (the ISSUE cycle).
  - deq_key holds its value until the next dequeue.
- ISSUE cycle:
  - arr_enb=1; arr_op and arr_key hold the registered opcode and key.
  - arr_key=0 for DEQ.
  - count updates on the edge ending ISSUE: ENQ +1, DEQ −1, REPLACE unchanged.
  - Next state is WAIT with settle counter = SETTLE−1.
- Outside ISSUE: arr_enb=0 and arr_op=00.
- WAIT: the counter decrements each cycle and the FSM returns to IDLE on the edge where it reads 0.
- Timing:
  - Accept edge at T; arr_enb high in cycle T+1; IDLE again at T+2+SETTLE.
  - Maximum throughput is one operation per SETTLE+2 cycles.
- count can never exceed DEPTH or go below 0, by construction of the ready rules. A simulation assertion checks both bounds.
- full and empty are decoded from the count register; there is no extra latency.

Test Plan:
1. Reset with enq_valid=1 held → enq_ready=1 (IDLE, empty) only after rst drops; count=0, empty=1, arr_enb=0 throughout reset.
2. Enqueue keys 5, 9, 3 back-to-back (SETTLE=2):
   - Each accept is followed by a one-cycle arr_enb with arr_op=01 and arr_key equal to the key.
   - Ready is low for 3 cycles between accepts; count ends at 3.
3. Model head=9 and issue a dequeue:
   - deq_key=9 with deq_key_valid pulsed one cycle after accept.
   - arr_op=10, count drops to 2.
4. With count=DEPTH:
   - enq alone → enq_ready=0.
   - enq+deq together → REPLACE (arr_op=11); count stays at DEPTH; deq_key = prior head.
5. Empty, enq+deq same cycle → only ENQ issued, deq_ready=0; DEQ accepted when IDLE returns with count=1.
6. Assert rst during WAIT → immediate return to IDLE, count=0, no deq_key_valid pulse; a new enqueue after reset completes normally.

Source files
------------

// File: rtl/qq_op_sched.sv
// Operation scheduler for the Quick Priority Queue register array: accepts enqueue/dequeue
// handshakes, merges a simultaneous pair into REPLACE and issues one strobed op at a time.
module qq_op_sched #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned KW     = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_valid,
  input  logic [KW-1:0]                enq_key,
  output logic                         enq_ready,
  input  logic                         deq_valid,
  output logic                         deq_ready,
  output logic [KW-1:0]                deq_key,
  output logic                         deq_key_valid,
  input  logic [KW-1:0]                arr_head_key,
  output logic                         arr_enb,
  output logic [1:0]                   arr_op,
  output logic [KW-1:0]                arr_key,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] OpEnq     = 2'b01;
  localparam logic [1:0] OpDeq     = 2'b10;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [1:0]      op_q, op_d;
  logic [KW-1:0]   key_q, key_d;
  logic [KW-1:0]   deq_key_q, deq_key_d;
  logic            deq_key_valid_q, deq_key_valid_d;
  logic            idle, enq_fire, deq_fire;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign idle  = (state_q == StIdle) && !rst;

  // A dequeue in the same cycle frees a slot, so enqueue is allowed even when full.
  assign deq_ready = idle && !empty;
  assign enq_ready = idle && (!full || (deq_valid && !empty));
  assign deq_fire  = deq_valid && deq_ready;
  assign enq_fire  = enq_valid && enq_ready;

  assign arr_enb       = (state_q == StIssue);
  assign arr_op        = arr_enb ? op_q : 2'b00;
  assign arr_key       = arr_enb ? key_q : '0;
  assign deq_key       = deq_key_q;
  assign deq_key_valid = deq_key_valid_q;

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    settle_d        = settle_q;
    op_d            = op_q;
    key_d           = key_q;
    deq_key_d       = deq_key_q;
    deq_key_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (deq_fire) begin
          deq_key_d       = arr_head_key;
          deq_key_valid_d = 1'b1;
        end
        if (enq_fire || deq_fire) begin
          state_d = StIssue;
          // Opcode encoding lets REPLACE fall out as both bits set.
          op_d    = {deq_fire, enq_fire};
          key_d   = enq_fire ? enq_key : '0;
        end
      end
      StIssue: begin
        state_d  = StWait;
        settle_d = SW'(SETTLE - 1);
        if (op_q == OpEnq) begin
          count_d = count_q + CW'(1);
        end else if (op_q == OpDeq) begin
          count_d = count_q - CW'(1);
        end
      end
      StWait: begin
        if (settle_q == '0) begin
          state_d = StIdle;
        end else begin
          settle_d = settle_q - SW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      count_q         <= '0;
      settle_q        <= '0;
      op_q            <= 2'b00;
      key_q           <= '0;
      deq_key_q       <= '0;
      deq_key_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      settle_q        <= settle_d;
      op_q            <= op_d;
      key_q           <= key_d;
      deq_key_q       <= deq_key_d;
      deq_key_valid_q <= deq_key_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CW'(DEPTH)) else $error("occupancy above DEPTH");
      assert (!(arr_enb && op_q == OpDeq && count_q == '0)) else $error("occupancy underflow");
      assert (!(arr_enb && op_q == OpEnq && count_q == CW'(DEPTH))) else
        $error("occupancy overflow");
    end
  end

endmodule

// File: tb/tb_qq_op_sched.sv
// Directed bench for qq_op_sched: handshakes, opcode strobes, occupancy and reset abort.
module tb_qq_op_sched;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned KW     = 8;
  localparam int unsigned SETTLE = 2;

  logic          clk, rst;
  logic          enq_valid, enq_ready, deq_valid, deq_ready;
  logic [KW-1:0] enq_key, deq_key, arr_head_key, arr_key;
  logic          deq_key_valid, arr_enb, full, empty;
  logic [1:0]    arr_op;
  logic [4:0]    count;

  int n_cmp = 0;
  int n_err = 0;

  qq_op_sched #(.DEPTH(DEPTH), .KW(KW), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .enq_valid    (enq_valid),
    .enq_key      (enq_key),
    .enq_ready    (enq_ready),
    .deq_valid    (deq_valid),
    .deq_ready    (deq_ready),
    .deq_key      (deq_key),
    .deq_key_valid(deq_key_valid),
    .arr_head_key (arr_head_key),
    .arr_enb      (arr_enb),
    .arr_op       (arr_op),
    .arr_key      (arr_key),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called one time unit after an edge with the DUT in IDLE; returns in IDLE again.
  task automatic do_op(input logic ev, input logic [KW-1:0] ek, input logic dv,
                       input logic [KW-1:0] head, input logic exp_erdy, input logic exp_drdy,
                       input logic [1:0] exp_op, input logic [KW-1:0] exp_key,
                       input logic exp_dkv, input logic [KW-1:0] exp_dk);
    enq_valid    = ev;
    enq_key      = ek;
    deq_valid    = dv;
    arr_head_key = head;
    #1;
    check_eq("enq_ready_idle", enq_ready, exp_erdy);
    check_eq("deq_ready_idle", deq_ready, exp_drdy);
    step();
    enq_valid    = 1'b0;
    deq_valid    = 1'b0;
    arr_head_key = 8'hEE;
    #1;
    check_eq("arr_enb_issue", arr_enb, 1'b1);
    check_eq("arr_op_issue", arr_op, exp_op);
    check_eq("arr_key_issue", arr_key, exp_key);
    check_eq("dkv_issue", deq_key_valid, exp_dkv);
    if (exp_dkv) check_eq("deq_key_issue", deq_key, exp_dk);
    for (int i = 0; i < SETTLE; i++) begin
      step();
      check_eq("enq_ready_wait", enq_ready, 1'b0);
      check_eq("arr_enb_wait", arr_enb, 1'b0);
      check_eq("dkv_wait", deq_key_valid, 1'b0);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; enq_valid = 1'b1; enq_key = 8'd5; deq_valid = 1'b0; arr_head_key = '0;
    step();
    step();
    check_eq("rst_enq_ready", enq_ready, 1'b0);
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1'b1);
    check_eq("rst_arr_enb", arr_enb, 1'b0);
    check_eq("rst_deq_key", deq_key, 0);
    rst = 1'b0;

    // Back-to-back enqueues 5, 9, 3
    do_op(1'b1, 8'd5, 1'b0, 8'd0, 1'b1, 1'b0, 2'b01, 8'd5, 1'b0, 8'd0);
    do_op(1'b1, 8'd9, 1'b0, 8'd5, 1'b1, 1'b1, 2'b01, 8'd9, 1'b0, 8'd0);
    do_op(1'b1, 8'd3, 1'b0, 8'd9, 1'b1, 1'b1, 2'b01, 8'd3, 1'b0, 8'd0);
    check_eq("count_after_3", count, 3);

    // Dequeue head 9
    do_op(1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b1, 2'b10, 8'd0, 1'b1, 8'd9);
    check_eq("count_after_deq", count, 2);
    check_eq("deq_key_hold", deq_key, 8'd9);

    // Fill to DEPTH
    for (int i = 0; i < DEPTH - 2; i++)
      do_op(1'b1, 8'(8'h20 + i), 1'b0, 8'd9, 1'b1, 1'b1, 2'b01, 8'(8'h20 + i), 1'b0, 8'd0);
    check_eq("count_full", count, DEPTH);
    check_eq("full_flag", full, 1'b1);
    check_eq("empty_flag_full", empty, 1'b0);

    enq_valid = 1'b1; enq_key = 8'h55; deq_valid = 1'b0;
    #1;
    check_eq("enq_ready_full", enq_ready, 1'b0);
    step();
    check_eq("no_issue_full", arr_enb, 1'b0);
    check_eq("count_full_hold", count, DEPTH);

    // Replace while full
    do_op(1'b1, 8'hAA, 1'b1, 8'h77, 1'b1, 1'b1, 2'b11, 8'hAA, 1'b1, 8'h77);
    check_eq("count_after_replace", count, DEPTH);

    // Drain to empty
    for (int i = 0; i < DEPTH; i++)
      do_op(1'b0, 8'd0, 1'b1, 8'(8'h60 + i), 1'b1, 1'b1, 2'b10, 8'd0, 1'b1, 8'(8'h60 + i));
    check_eq("count_drained", count, 0);
    check_eq("empty_drained", empty, 1'b1);
    check_eq("deq_key_last", deq_key, 8'h6F);

    // Empty with both valid: only ENQ goes, DEQ retried afterwards
    do_op(1'b1, 8'h42, 1'b1, 8'h00, 1'b1, 1'b0, 2'b01, 8'h42, 1'b0, 8'd0);
    check_eq("count_enq_only", count, 1);
    do_op(1'b0, 8'd0, 1'b1, 8'h42, 1'b1, 1'b1, 2'b10, 8'd0, 1'b1, 8'h42);
    check_eq("count_retry_deq", count, 0);

    // Enqueue then a dequeue aborted by reset during WAIT
    do_op(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 8'h11, 1'b0, 8'd0);
    deq_valid = 1'b1; arr_head_key = 8'h11;
    step();
    deq_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check_eq("abort_count", count, 0);
    check_eq("abort_arr_enb", arr_enb, 1'b0);
    check_eq("abort_dkv", deq_key_valid, 1'b0);
    check_eq("abort_deq_key", deq_key, 0);
    check_eq("abort_enq_ready", enq_ready, 1'b0);
    step();
    rst = 1'b0;
    #1;
    check_eq("post_rst_enq_ready", enq_ready, 1'b1);
    check_eq("post_rst_dkv", deq_key_valid, 1'b0);
    check_eq("post_rst_empty", empty, 1'b1);
    do_op(1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 8'h22, 1'b0, 8'd0);
    check_eq("post_rst_count", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
